// File: rtl/io_master.sv
// io_master: single-outstanding CPU-to-peripheral IO bus master.
// A request accepted in IDLE is driven onto the peripheral bus during ACCESS
// until the peripheral signals ready or the cycle budget runs out. The result
// is reported as a one-cycle pulse in RESP.
module io_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [15:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [15:0] o_addr,
  output logic        o_sel,
  output logic        o_we,
  output logic        o_re,
  output logic [15:0] o_wdata,
  input  logic [15:0] i_rdata,
  input  logic        i_rdy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Counter value seen in the final permitted ACCESS cycle (counter starts at 0).
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [15:0] r_resp_rdata;
  logic        r_resp_err;
  logic [15:0] r_addr;
  logic        r_sel;
  logic        r_we;
  logic        r_re;
  logic [15:0] r_wdata;

  // The bus registers double as the latched request: they hold the accepted
  // we/addr/wdata for the whole ACCESS phase and are zeroed outside it.
  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_addr       <= '0;
      r_sel        <= 1'b0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_state     <= S_ACCESS;
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            r_sel       <= 1'b1;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_we        <= i_req_we;
            r_re        <= ~i_req_we;
          end
        end
        S_ACCESS: begin
          // Ready takes priority over timeout in the last permitted cycle.
          if (i_rdy || (r_cnt == LP_LAST)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= ~i_rdy;
            r_resp_rdata <= (i_rdy && !r_we) ? i_rdata : '0;
            r_sel        <= 1'b0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_addr       = r_addr;
  assign o_sel        = r_sel;
  assign o_we         = r_we;
  assign o_re         = r_re;
  assign o_wdata      = r_wdata;

endmodule

// File: tb/tb_io_master.sv
// Testbench for io_master: directed requests push expected bus activity and
// responses into queues; independent monitors pop and compare them.
module tb_io_master;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [15:0] i_req_addr = '0;
  logic [15:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [15:0] o_resp_rdata;
  logic        o_resp_err;
  logic [15:0] o_addr;
  logic        o_sel;
  logic        o_we;
  logic        o_re;
  logic [15:0] o_wdata;
  logic [15:0] i_rdata = '0;
  logic        i_rdy = 1'b0;

  io_master #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_addr(o_addr), .o_sel(o_sel), .o_we(o_we), .o_re(o_re), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .i_rdy(i_rdy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    int          cycles;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    prev_sel = 1'b0;
  int    sel_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor plus ready/exclusivity invariants.
  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("ready_only_idle", {31'd0, o_req_ready}, {31'd0, !(o_sel || o_resp_valid)});
      chk("we_re_exclusive", {31'd0, o_we && o_re}, 32'd0);
      if (o_resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          chk("resp_rdata", {16'd0, o_resp_rdata}, {16'd0, rq[0].rdata});
          chk("resp_err", {31'd0, o_resp_err}, {31'd0, rq[0].err});
          chk("resp_latency", cyc, rq[0].cyc);
          void'(rq.pop_front());
        end
      end
    end
  end

  // Bus monitor: per-cycle values while selected, idle zeros otherwise,
  // and select length once it drops.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_sel) begin
        if (bq.size() == 0) begin
          chk("unexpected_sel", 32'd1, 32'd0);
        end else begin
          chk("bus_addr", {16'd0, o_addr}, {16'd0, bq[0].addr});
          chk("bus_wdata", {16'd0, o_wdata}, {16'd0, bq[0].wdata});
          chk("bus_we", {31'd0, o_we}, {31'd0, bq[0].we});
          chk("bus_re", {31'd0, o_re}, {31'd0, !bq[0].we});
        end
        sel_cnt++;
      end else begin
        chk("bus_idle_zero", {o_addr, o_wdata}, 32'd0);
        chk("bus_idle_ctl", {30'd0, o_we, o_re}, 32'd0);
        if (prev_sel && bq.size() != 0) begin
          chk("sel_cycles", sel_cnt, bq[0].cycles);
          void'(bq.pop_front());
        end
        sel_cnt = 0;
      end
      prev_sel = o_sel;
    end
  end

  // Issue one request and act as the peripheral: ready stays low for 'waits'
  // ACCESS cycles, then rises with pdata on i_rdata.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int waits, input logic [15:0] pdata, input bit keep,
                       input logic [15:0] exp_rdata, input logic exp_err,
                       input int exp_sel, output int acc);
    bus_t  b;
    resp_t r;
    bit    ok;
    @(negedge i_clk);
    i_rdy       = 1'b1;
    i_rdata     = 16'hFFFF;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      i_req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge i_clk);
    #1;
    acc = cyc;
    b.addr = addr; b.wdata = wdata; b.we = we; b.cycles = exp_sel;
    bq.push_back(b);
    r.rdata = exp_rdata; r.err = exp_err; r.cyc = acc + exp_sel;
    rq.push_back(r);
    for (int k = 0; k < exp_sel; k++) begin
      @(negedge i_clk);
      if (k == 0) begin
        i_req_we    = ~we;
        i_req_addr  = 16'hFFFF;
        i_req_wdata = 16'h0BAD;
        if (!keep) i_req_valid = 1'b0;
      end
      i_rdy   = (k >= waits);
      i_rdata = (k >= waits) ? pdata : 16'h5A5A;
    end
  endtask

  initial begin
    int a1, a2;
    bit ok;
    bus_t b;

    // Reset with a request pending: nothing may be accepted.
    i_rst = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr = 16'h1111;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_sel_we_re", {29'd0, o_sel, o_we, o_re}, 32'd0);
    chk("rst_addr_wdata", {o_addr, o_wdata}, 32'd0);
    chk("rst_resp", {14'd0, o_resp_valid, o_resp_err, o_resp_rdata}, 32'd0);
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    mon_en = 1'b1;

    // Write, immediate ready; i_rdata must be ignored for writes.
    issue(1'b1, 16'h0302, 16'hA5A5, 0, 16'hCAFE, 1'b0, 16'h0000, 1'b0, 1, a1);
    // Read, three wait cycles.
    issue(1'b0, 16'h0F02, 16'h0000, 3, 16'h1234, 1'b0, 16'h1234, 1'b0, 4, a1);
    repeat (4) @(negedge i_clk);
    chk("resp_hold_rdata", {16'd0, o_resp_rdata}, 32'h1234);
    chk("resp_hold_err", {31'd0, o_resp_err}, 32'd0);

    // Read timeout after 8 ACCESS cycles, then ready returns.
    issue(1'b0, 16'h0100, 16'h0000, 8, 16'h7777, 1'b0, 16'h0000, 1'b1, 8, a1);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("ready_after_timeout", {31'd0, o_req_ready}, 32'd1);
    // Ready in the last permitted cycle wins.
    issue(1'b0, 16'h0200, 16'h0000, 7, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 8, a1);
    // Write timeout.
    issue(1'b1, 16'h0300, 16'h4321, 8, 16'h9999, 1'b0, 16'h0000, 1'b1, 8, a1);

    // Back-to-back with valid held high.
    issue(1'b1, 16'h1000, 16'h1111, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1, a1);
    issue(1'b0, 16'h2000, 16'h0000, 0, 16'h2222, 1'b0, 16'h2222, 1'b0, 1, a2);
    chk("b2b_spacing", a2 - a1, 32'd3);

    // Reset in the second ACCESS cycle aborts without a response.
    @(negedge i_clk);
    i_rdy = 1'b0;
    i_req_we = 1'b0;
    i_req_addr = 16'h0444;
    i_req_wdata = 16'h0055;
    i_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    chk("abort_accept", {31'd0, ok}, 32'd1);
    @(posedge i_clk);
    #1;
    b.addr = 16'h0444; b.wdata = 16'h0055; b.we = 1'b0; b.cycles = 2;
    bq.push_back(b);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    chk("abort_sel", {31'd0, o_sel}, 32'd0);
    chk("abort_ready", {31'd0, o_req_ready}, 32'd1);
    @(negedge i_clk);
    chk("abort_no_accept", {31'd0, o_sel}, 32'd0);
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    repeat (12) @(negedge i_clk);

    chk("resp_queue_empty", rq.size(), 32'd0);
    chk("bus_queue_empty", bq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
